// File: rtl/modadd_cs_pipe.sv
// Pipelined modular adder/subtractor mod P on carry-save operands, with valid/ready and a tag.
// Define MODADD_CANON_OUT_EN to add a third stage that emits the canonical residue in out_s.
`timescale 1ns/1ps
module modadd_cs_pipe #(
    parameter int unsigned    W     = 40,
    parameter logic [W-1:0]   P     = 40'h85bfc65fef,
    parameter int unsigned    TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [W-1:0]     a_c,
    input  logic [W-1:0]     a_s,
    input  logic [W-1:0]     b_c,
    input  logic [W-1:0]     b_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [W-1:0]     out_c,
    output logic [W-1:0]     out_s
);

    localparam int unsigned XW = W + 3;
    localparam int unsigned FW = W + 5;

    function automatic logic [W-1:0] mod_p(input logic [FW-1:0] x);
        logic [FW-1:0] pm;
        logic [FW-1:0] r;
        pm = '0;
        pm[W-1:0] = P;
        r = x % pm;
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] corr_entry(input logic [3:0] m);
        logic [FW-1:0] t;
        t = '0;
        t[3:0] = m;
        return mod_p(t << (W - 1));
    endfunction

    // (2 - 2^(W+1)) mod P: cancels the offset introduced by inverting both B words.
    function automatic logic [W-1:0] sub_const();
        logic [FW-1:0] pm;
        logic [FW-1:0] t;
        logic [FW-1:0] r;
        logic [FW-1:0] two;
        pm = '0;
        pm[W-1:0] = P;
        t = '0;
        t[W+1] = 1'b1;
        r = '0;
        r[W-1:0] = mod_p(t);
        two = '0;
        two[1] = 1'b1;
        return mod_p(pm - r + two);
    endfunction

    localparam logic [W-1:0] SUB_K = sub_const();

    function automatic logic [2*XW-1:0] csa(input logic [XW-1:0] x, input logic [XW-1:0] y,
                                           input logic [XW-1:0] z);
        logic [XW-1:0] s;
        logic [XW-1:0] c;
        s = x ^ y ^ z;
        c = {(x[XW-2:0] & y[XW-2:0]) | (x[XW-2:0] & z[XW-2:0]) | (y[XW-2:0] & z[XW-2:0]),
             1'b0};
        return {c, s};
    endfunction

    logic [W-1:0] corr_tab [16];
    for (genvar gi = 0; gi < 16; gi++) begin : g_corr
        assign corr_tab[gi] = corr_entry(4'(gi));
    end

    logic             en1;
    logic             en2;
    logic             v1_q;
    logic [XW-1:0]    s1_c_q;
    logic [XW-1:0]    s1_s_q;
    logic [TAG_W-1:0] s1_tag_q;
    logic             v2_q;
    logic [W-1:0]     s2_c_q;
    logic [W-1:0]     s2_s_q;
    logic [TAG_W-1:0] s2_tag_q;

    // S1: 5:2 compression via three chained 3:2 levels.
    logic [XW-1:0]   w0, w1, w2, w3, w4;
    logic [2*XW-1:0] l1, l2, l3;
    logic [XW-1:0]   s1_c_d, s1_s_d;

    always_comb begin
        w0 = {3'b000, a_c};
        w1 = {3'b000, a_s};
        w2 = {3'b000, in_sub ? ~b_c : b_c};
        w3 = {3'b000, in_sub ? ~b_s : b_s};
        w4 = in_sub ? {3'b000, SUB_K} : '0;
        l1 = csa(w0, w1, w2);
        l2 = csa(l1[2*XW-1:XW], l1[XW-1:0], w3);
        l3 = csa(l2[2*XW-1:XW], l2[XW-1:0], w4);
        s1_c_d = l3[2*XW-1:XW];
        s1_s_d = l3[XW-1:0];
    end

    // S2: fold bits at and above W-1 back in as a precomputed residue. The S1 sum is below
    // 5*2^W, so M <= 9 and fits the 16-entry table.
    logic [3:0]   m;
    logic [W-1:0] corr;
    logic [W-2:0] c_lo, s_lo, maj_lo;
    logic [W-1:0] s2_c_d, s2_s_d;

    always_comb begin
        m      = s1_c_q[XW-1:W-1] + s1_s_q[XW-1:W-1];
        corr   = corr_tab[m];
        c_lo   = s1_c_q[W-2:0];
        s_lo   = s1_s_q[W-2:0];
        maj_lo = (c_lo & s_lo) | (c_lo & corr[W-2:0]) | (s_lo & corr[W-2:0]);
        s2_s_d = {corr[W-1], c_lo ^ s_lo ^ corr[W-2:0]};
        s2_c_d = {maj_lo, 1'b0};
    end

    assign en1      = !v1_q || en2;
    assign in_ready = en1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            s1_c_q   <= '0;
            s1_s_q   <= '0;
            s1_tag_q <= '0;
            v2_q     <= 1'b0;
            s2_c_q   <= '0;
            s2_s_q   <= '0;
            s2_tag_q <= '0;
        end else begin
            if (en1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    s1_c_q   <= s1_c_d;
                    s1_s_q   <= s1_s_d;
                    s1_tag_q <= in_tag;
                end
            end
            if (en2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    s2_c_q   <= s2_c_d;
                    s2_s_q   <= s2_s_d;
                    s2_tag_q <= s1_tag_q;
                end
            end
        end
    end

`ifdef MODADD_CANON_OUT_EN
    localparam logic [W:0] P_EXT = {1'b0, P};

    logic             en3;
    logic             v3_q;
    logic [W-1:0]     s3_s_q;
    logic [TAG_W-1:0] s3_tag_q;
    logic [W:0]       sum_raw, sum1;
    logic [W-1:0]     canon_d;

    // Raw sum is below 2^W + P <= 3P, so two conditional subtracts reach [0, P).
    always_comb begin
        sum_raw = {1'b0, s2_c_q} + {1'b0, s2_s_q};
        sum1    = (sum_raw >= P_EXT) ? sum_raw - P_EXT : sum_raw;
        canon_d = W'((sum1 >= P_EXT) ? sum1 - P_EXT : sum1);
    end

    assign en3 = !v3_q || out_ready;
    assign en2 = !v2_q || en3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q     <= 1'b0;
            s3_s_q   <= '0;
            s3_tag_q <= '0;
        end else if (en3) begin
            v3_q <= v2_q;
            if (v2_q) begin
                s3_s_q   <= canon_d;
                s3_tag_q <= s2_tag_q;
            end
        end
    end

    assign out_valid = v3_q;
    assign out_tag   = s3_tag_q;
    assign out_c     = '0;
    assign out_s     = s3_s_q;
`else
    assign en2       = !v2_q || out_ready;
    assign out_valid = v2_q;
    assign out_tag   = s2_tag_q;
    assign out_c     = s2_c_q;
    assign out_s     = s2_s_q;
`endif

endmodule
